alu_pipe_param: RTL and testbench

//  Parametrised, handshaked successor of the datapath ALU; generalises width to WIDTH with a half-width mode.

---
 rtl/alu_pipe_param.sv | 154 +++++++++++++++
 tb/tb_alu_pipe_param.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_param.sv
// Parametrised handshaked ALU with registered result/flags and an iterative
// shift-add unsigned multiplier; half-width mode operates on the low HALF bits.
module alu_pipe_param #(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [5:0]       FunSel,
   input  logic             WF,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] ALUOut,
   output logic [3:0]       FlagsOut,
   output logic             Busy
);

   localparam int HALF = WIDTH / 2;
   localparam int IW   = $clog2(WIDTH);
   localparam int CW   = $clog2(HALF);

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state;
   logic [WIDTH-1:0] mul_a;
   logic [HALF-1:0]  mul_b;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             mul_wf;

   logic             full, is_ext, is_mul, issue, pop, cin;
   logic [IW-1:0]    msb;
   logic [WIDTH-1:0] mask, a_op, b_op, res, acc_next;
   logic [WIDTH:0]   sum;
   logic             c_new, o_new, z_new, n_new;
   logic [3:0]       new_flags;

   assign full    = FunSel[4];
   assign is_ext  = FunSel[5];
   assign is_mul  = MUL_EN && is_ext && (FunSel[3:0] == 4'd0);
   assign Busy    = (state == MUL);
   assign InReady = !Reset && !Busy && (!OutValid || OutReady);
   assign issue   = InValid && InReady;
   assign pop     = OutValid && OutReady;
   assign cin     = FlagsOut[2];

   assign msb  = full ? IW'(WIDTH - 1) : IW'(HALF - 1);
   assign mask = full ? {WIDTH{1'b1}} : {{HALF{1'b0}}, {HALF{1'b1}}};
   assign a_op = A & mask;
   assign b_op = B & mask;

   // Single-cycle datapath; sum is evaluated at full width so the carry of a
   // half-width add lands in bit HALF while bit msb still gives the sign.
   always_comb begin
      res   = '0;
      sum   = '0;
      c_new = FlagsOut[2];
      o_new = FlagsOut[0];
      case (FunSel[3:0])
         4'd0:  res = a_op;
         4'd1:  res = b_op;
         4'd2:  res = ~a_op;
         4'd3:  res = ~b_op;
         4'd4, 4'd5: begin
            sum   = {1'b0, a_op} + {1'b0, b_op}
                    + {{WIDTH{1'b0}}, (FunSel[3:0] == 4'd5) & cin};
            res   = sum[WIDTH-1:0];
            c_new = full ? sum[WIDTH] : sum[HALF];
            o_new = (a_op[msb] == b_op[msb]) && (sum[msb] != a_op[msb]);
         end
         4'd6: begin
            sum   = {1'b0, a_op} - {1'b0, b_op};
            res   = sum[WIDTH-1:0];
            c_new = (a_op < b_op);
            o_new = (a_op[msb] != b_op[msb]) && (sum[msb] != a_op[msb]);
         end
         4'd7:  res = a_op & b_op;
         4'd8:  res = a_op | b_op;
         4'd9:  res = a_op ^ b_op;
         4'd10: res = ~(a_op & b_op);
         4'd11: begin res = a_op << 1; c_new = a_op[msb]; end
         4'd12: begin res = a_op >> 1; c_new = a_op[0]; end
         4'd13: begin res = (a_op >> 1) | (WIDTH'(a_op[msb]) << msb); c_new = a_op[0]; end
         4'd14: begin res = (a_op << 1) | WIDTH'(cin); c_new = a_op[msb]; end
         default: begin res = (a_op >> 1) | (WIDTH'(cin) << msb); c_new = a_op[0]; end
      endcase
      res = res & mask;
   end

   assign z_new     = (res == '0);
   assign n_new     = res[msb];
   assign new_flags = {z_new, c_new, n_new, o_new};
   assign acc_next  = acc + (mul_b[0] ? mul_a : '0);

   // Handshake, result/flag registers and the multiply FSM share one process.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         ALUOut   <= '0;
         FlagsOut <= '0;
         OutValid <= 1'b0;
         mul_a    <= '0;
         mul_b    <= '0;
         acc      <= '0;
         cnt      <= '0;
         mul_wf   <= 1'b0;
      end else begin
         if (pop)
            OutValid <= 1'b0;
         case (state)
            IDLE: begin
               if (issue) begin
                  if (is_mul) begin
                     state    <= MUL;
                     mul_a    <= {{HALF{1'b0}}, A[HALF-1:0]};
                     mul_b    <= B[HALF-1:0];
                     acc      <= '0;
                     cnt      <= '0;
                     mul_wf   <= WF;
                     OutValid <= 1'b0;
                  end else if (is_ext) begin
                     ALUOut   <= '0;
                     OutValid <= 1'b1;
                  end else begin
                     ALUOut   <= res;
                     OutValid <= 1'b1;
                     if (WF)
                        FlagsOut <= new_flags;
                  end
               end
            end
            MUL: begin
               acc   <= acc_next;
               mul_a <= mul_a << 1;
               mul_b <= mul_b >> 1;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(HALF - 1)) begin
                  state    <= IDLE;
                  ALUOut   <= acc_next;
                  OutValid <= 1'b1;
                  if (mul_wf)
                     FlagsOut <= {(acc_next == '0), 1'b0, acc_next[WIDTH-1], FlagsOut[0]};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed-vector bench for alu_pipe_param (WIDTH=16, MUL_EN=1) with
// hand-computed expectations checked by immediate assertions.
module tb_alu_pipe_param;

   logic        Clock = 1'b0;
   logic        Reset, InValid, InReady, WF, OutValid, OutReady, Busy;
   logic [15:0] A, B, ALUOut;
   logic [5:0]  FunSel;
   logic [3:0]  FlagsOut;

   int vectors = 0;
   int miscompares = 0;

   alu_pipe_param #(.WIDTH(16), .MUL_EN(1'b1)) dut (
      .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .A(A), .B(B), .FunSel(FunSel), .WF(WF), .OutValid(OutValid),
      .OutReady(OutReady), .ALUOut(ALUOut), .FlagsOut(FlagsOut), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic applyStimulus(input logic iv, input logic [5:0] fs,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic wf);
      InValid = iv;
      FunSel  = fs;
      A       = a;
      B       = b;
      WF      = wf;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs,
                              input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset = 1'b1; OutReady = 1'b0;
      applyStimulus(1'b0, 6'd0, 16'h0000, 16'h0000, 1'b0);
      step(); step();
      checkOutput("rst_aluout", ALUOut, 16'h0000);
      checkOutput("rst_flags", {12'h0, FlagsOut}, 16'h0000);
      checkOutput("rst_outvalid", {15'h0, OutValid}, 16'h0000);
      checkOutput("rst_busy", {15'h0, Busy}, 16'h0000);
      checkOutput("rst_inready", {15'h0, InReady}, 16'h0000);
      Reset = 1'b0;
      #1;
      checkOutput("post_rst_inready", {15'h0, InReady}, 16'h0001);

      // Full add with signed overflow.
      applyStimulus(1'b1, 6'b010100, 16'h7FFF, 16'h0001, 1'b1);
      step();
      checkOutput("add_ovf_out", ALUOut, 16'h8000);
      checkOutput("add_ovf_flags", {12'h0, FlagsOut}, 16'h0003);
      checkOutput("add_ovf_valid", {15'h0, OutValid}, 16'h0001);

      // Half-width subtract with borrow; pop and issue in the same cycle.
      OutReady = 1'b1;
      applyStimulus(1'b1, 6'b000110, 16'h1205, 16'h3407, 1'b1);
      step();
      checkOutput("hsub_out", ALUOut, 16'h00FE);
      checkOutput("hsub_flags", {12'h0, FlagsOut}, 16'h0006);
      checkOutput("hsub_valid", {15'h0, OutValid}, 16'h0001);

      // Back-to-back: carry from the ADD feeds the ADC.
      applyStimulus(1'b1, 6'b010100, 16'hFFFF, 16'h0001, 1'b1);
      step();
      checkOutput("add_wrap_out", ALUOut, 16'h0000);
      checkOutput("add_wrap_flags", {12'h0, FlagsOut}, 16'h000C);
      applyStimulus(1'b1, 6'b010101, 16'h0000, 16'h0000, 1'b1);
      step();
      checkOutput("adc_out", ALUOut, 16'h0001);
      checkOutput("adc_flags", {12'h0, FlagsOut}, 16'h0000);

      // Multiply 0xFF*0xFF: busy for 8 cycles, result on the 9th edge.
      applyStimulus(1'b1, 6'b110000, 16'h00FF, 16'h00FF, 1'b1);
      step();
      applyStimulus(1'b0, 6'b000000, 16'h0000, 16'h0000, 1'b0);
      checkOutput("mul_start_busy", {15'h0, Busy}, 16'h0001);
      checkOutput("mul_start_inready", {15'h0, InReady}, 16'h0000);
      checkOutput("mul_start_valid", {15'h0, OutValid}, 16'h0000);
      for (int k = 0; k < 7; k++) begin
         step();
         checkOutput("mul_busy", {15'h0, Busy}, 16'h0001);
         checkOutput("mul_no_valid", {15'h0, OutValid}, 16'h0000);
      end
      step();
      checkOutput("mul_done_busy", {15'h0, Busy}, 16'h0000);
      checkOutput("mul_done_valid", {15'h0, OutValid}, 16'h0001);
      checkOutput("mul_product", ALUOut, 16'hFE01);
      checkOutput("mul_flags", {12'h0, FlagsOut}, 16'h0002);

      // Backpressure: result holds, new requests are ignored.
      OutReady = 1'b0;
      applyStimulus(1'b1, 6'b010001, 16'h0000, 16'h1234, 1'b1);
      #1;
      checkOutput("bp_inready", {15'h0, InReady}, 16'h0000);
      step(); step();
      checkOutput("bp_hold_out", ALUOut, 16'hFE01);
      checkOutput("bp_hold_valid", {15'h0, OutValid}, 16'h0001);
      checkOutput("bp_hold_flags", {12'h0, FlagsOut}, 16'h0002);
      OutReady = 1'b1;
      applyStimulus(1'b1, 6'b010010, 16'h00FF, 16'h0000, 1'b0);
      step();
      checkOutput("nota_out", ALUOut, 16'hFF00);
      checkOutput("nota_wf0_flags", {12'h0, FlagsOut}, 16'h0002);
      applyStimulus(1'b0, 6'b000000, 16'h0000, 16'h0000, 1'b0);
      step();
      checkOutput("pop_clears_valid", {15'h0, OutValid}, 16'h0000);

      // Reserved extended code returns zero and leaves flags alone.
      applyStimulus(1'b1, 6'b100001, 16'h5555, 16'h3333, 1'b1);
      step();
      checkOutput("rsv_out", ALUOut, 16'h0000);
      checkOutput("rsv_valid", {15'h0, OutValid}, 16'h0001);
      checkOutput("rsv_flags", {12'h0, FlagsOut}, 16'h0002);

      // Half-width ASR uses bit 7 as the sign.
      applyStimulus(1'b1, 6'b001101, 16'hAA81, 16'h0000, 1'b1);
      step();
      checkOutput("hasr_out", ALUOut, 16'h00C0);
      checkOutput("hasr_flags", {12'h0, FlagsOut}, 16'h0006);

      // Full CSR rotates the carry into bit 15.
      applyStimulus(1'b1, 6'b011111, 16'h0002, 16'h0000, 1'b1);
      step();
      checkOutput("csr_out", ALUOut, 16'h8001);
      checkOutput("csr_flags", {12'h0, FlagsOut}, 16'h0002);

      // Reset during a multiply aborts it without a result.
      applyStimulus(1'b1, 6'b110000, 16'h0003, 16'h0005, 1'b1);
      step();
      applyStimulus(1'b0, 6'b000000, 16'h0000, 16'h0000, 1'b0);
      step(); step(); step();
      Reset = 1'b1;
      step();
      checkOutput("abort_busy", {15'h0, Busy}, 16'h0000);
      checkOutput("abort_valid", {15'h0, OutValid}, 16'h0000);
      checkOutput("abort_flags", {12'h0, FlagsOut}, 16'h0000);
      checkOutput("abort_inready_rst", {15'h0, InReady}, 16'h0000);
      Reset = 1'b0;
      #1;
      checkOutput("abort_inready", {15'h0, InReady}, 16'h0001);
      for (int k = 0; k < 10; k++) step();
      checkOutput("abort_no_product_valid", {15'h0, OutValid}, 16'h0000);
      checkOutput("abort_no_product_out", ALUOut, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
